// File: rtl/icache_pair_responder.sv
// Direct-mapped instruction cache returning the word at Addr and the word at Addr+4,
// with a single-line refill engine driven by a valid/last beat handshake.
module icache_pair_responder #(
  parameter int INDEX_BITS = 4,
  parameter int LINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Addr,
  output logic [63:0] Instr,
  output logic        TLBExpection,
  output logic        Stall,
  output logic        MemReq,
  output logic [31:0] MemAddr,
  input  logic [31:0] MemRData,
  input  logic        MemValid,
  input  logic        MemLast
);

  localparam int O       = $clog2(LINE_WORDS);
  localparam int LINES   = 1 << INDEX_BITS;
  localparam int TAG_LSB = O + INDEX_BITS + 2;
  localparam int TAG_W   = 32 - TAG_LSB;
  localparam logic [O:0] BEATS     = (O+1)'(LINE_WORDS);
  localparam logic [O:0] LAST_BEAT = (O+1)'(LINE_WORDS - 1);
  localparam logic [O:0] ONE       = (O+1)'(1);

  typedef enum logic [1:0] {S_IDLE, S_REFILL, S_FILL} state_t;

  state_t                       state_q;
  logic [O:0]                   cnt_q;
  logic                         memreq_q;
  logic [31:0]                  memaddr_q;
  logic [LINES-1:0]             valid_q;
  logic [TAG_W-1:0]             tag_q  [LINES];
  logic [LINE_WORDS-1:0][31:0]  data_q [LINES];
  logic [LINE_WORDS-1:0][31:0]  buf_q;

  logic [31:0]           addr_b;
  logic [O-1:0]          off_a, off_b;
  logic [INDEX_BITS-1:0] idx_a, idx_b, idx_f;
  logic [TAG_W-1:0]      tag_a, tag_b, tag_f;
  logic                  hit_a, hit_b;
  logic [31:0]           word_a, word_b;
  logic                  unused_bits;

  // Word B is an independent lookup; it lands in the next line (mod 2^32) at the last offset.
  assign addr_b = Addr + 32'd4;
  assign off_a  = Addr[O+1:2];
  assign idx_a  = Addr[TAG_LSB-1:O+2];
  assign tag_a  = Addr[31:TAG_LSB];
  assign off_b  = addr_b[O+1:2];
  assign idx_b  = addr_b[TAG_LSB-1:O+2];
  assign tag_b  = addr_b[31:TAG_LSB];
  assign idx_f  = memaddr_q[TAG_LSB-1:O+2];
  assign tag_f  = memaddr_q[31:TAG_LSB];

  assign hit_a  = valid_q[idx_a] && (tag_q[idx_a] == tag_a);
  assign hit_b  = valid_q[idx_b] && (tag_q[idx_b] == tag_b);
  assign word_a = data_q[idx_a][off_a];
  assign word_b = data_q[idx_b][off_b];

  assign unused_bits = ^{Addr[1:0], addr_b[1:0]};

  always_comb begin
    Stall        = 1'b1;
    Instr        = '0;
    TLBExpection = 1'b0;
    if (state_q == S_IDLE && hit_a) begin
      Stall        = 1'b0;
      TLBExpection = !hit_b;
      Instr        = hit_b ? {word_b, word_a} : {32'h0, word_a};
    end
  end

  assign MemReq  = memreq_q;
  assign MemAddr = memaddr_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      memreq_q  <= 1'b0;
      memaddr_q <= '0;
      valid_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!hit_a) begin
            memaddr_q <= {Addr[31:O+2], {(O+2){1'b0}}};
            memreq_q  <= 1'b1;
            cnt_q     <= '0;
            state_q   <= S_REFILL;
          end
        end
        S_REFILL: begin
          // Counter saturates at LINE_WORDS so surplus beats fall off the end.
          if (MemValid) begin
            if (cnt_q != BEATS) cnt_q <= cnt_q + ONE;
            if (MemLast) begin
              memreq_q <= 1'b0;
              state_q  <= S_FILL;
            end
          end
        end
        S_FILL: begin
          valid_q[idx_f] <= 1'b1;
          state_q        <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Line storage carries no reset; the valid bits alone qualify it.
  always_ff @(posedge clk) begin
    if (state_q == S_REFILL && MemValid && cnt_q != BEATS)
      buf_q[cnt_q[O-1:0]] <= MemRData;
    if (state_q == S_FILL) begin
      data_q[idx_f] <= buf_q;
      tag_q[idx_f]  <= tag_f;
    end
  end

  a_full_line: assert property (@(posedge clk) disable iff (reset)
    (state_q == S_REFILL && MemValid && MemLast) |-> (cnt_q >= LAST_BEAT));

endmodule

// File: tb/tb_icache_pair_responder.sv
// Randomised scoreboard bench for icache_pair_responder: a line-residency model predicts
// each fetch's pair, TLBExpection, stall length and refill address.
module tb_icache_pair_responder;

  localparam int INDEX_BITS = 4;
  localparam int LINE_WORDS = 4;
  localparam int LAT        = 3;
  localparam int LINES      = 1 << INDEX_BITS;
  localparam int LINE_BYTES = LINE_WORDS * 4;
  localparam logic [31:0] LMASK = ~32'(LINE_BYTES - 1);

  logic        clk;
  logic        reset;
  logic [31:0] Addr;
  logic [63:0] Instr;
  logic        TLBExpection;
  logic        Stall;
  logic        MemReq;
  logic [31:0] MemAddr;
  logic [31:0] MemRData;
  logic        MemValid;
  logic        MemLast;

  logic        r_valid, r_last, s_valid, s_last, r_busy;
  logic [31:0] r_data, s_data;

  assign MemValid = r_valid | s_valid;
  assign MemLast  = r_last | s_last;
  assign MemRData = s_valid ? s_data : r_data;

  icache_pair_responder #(.INDEX_BITS(INDEX_BITS), .LINE_WORDS(LINE_WORDS)) dut (
    .clk(clk), .reset(reset), .Addr(Addr), .Instr(Instr), .TLBExpection(TLBExpection),
    .Stall(Stall), .MemReq(MemReq), .MemAddr(MemAddr), .MemRData(MemRData),
    .MemValid(MemValid), .MemLast(MemLast));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endfunction

  // Backing memory: line 0 holds 0x11,0x22,0x33,0x44; everything else is a hash.
  function automatic logic [31:0] memfn(input logic [31:0] a);
    logic [31:0] w;
    w = a & 32'hFFFF_FFFC;
    if (w < 32'h10) return 32'h11 * (32'(w[3:2]) + 32'd1);
    return (w * 32'h9E37_79B1) ^ 32'hC0DE_0000 ^ w;
  endfunction

  bit          res_v  [LINES];
  logic [31:0] res_la [LINES];

  function automatic int idx_of(input logic [31:0] a);
    return int'((a / 32'(LINE_BYTES)) % 32'(LINES));
  endfunction

  function automatic bit resident(input logic [31:0] a);
    return res_v[idx_of(a)] && (res_la[idx_of(a)] == (a & LMASK));
  endfunction

  typedef struct {
    logic [63:0] instr;
    logic        tlb;
    int          stall;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] refill_q[$];
  bit          pending = 0;

  task automatic summary_and_finish();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  endtask

  // Called #1 after a posedge; returns #1 after the posedge following the response.
  task automatic issue(input logic [31:0] a);
    exp_t        e;
    logic [31:0] b;
    Addr    = a;
    e.stall = 0;
    if (!resident(a)) begin
      refill_q.push_back(a & LMASK);
      res_v[idx_of(a)]  = 1'b1;
      res_la[idx_of(a)] = a & LMASK;
      e.stall = LAT + LINE_WORDS + 2;
    end
    b = a + 32'd4;
    if (resident(b)) begin
      e.instr = {memfn(b), memfn(a)};
      e.tlb   = 1'b0;
    end else begin
      e.instr = {32'h0, memfn(a)};
      e.tlb   = 1'b1;
    end
    exp_q.push_back(e);
    pending = 1;
    for (int k = 0; k < 60; k++) begin
      if (!pending) break;
      @(posedge clk);
    end
    if (pending) begin
      checks++;
      errors++;
      $display("FAIL fetch_timeout addr=%h stall=%0d", a, Stall);
      summary_and_finish();
    end
    #1;
  endtask

  // Memory bus: first beat LAT cycles after MemReq rises, then LINE_WORDS back-to-back beats.
  initial begin
    logic [31:0] la;
    r_valid = 0; r_last = 0; r_data = 0; r_busy = 0;
    forever begin
      @(negedge clk);
      if (MemReq && !reset) begin
        la     = MemAddr;
        r_busy = 1;
        repeat (LAT) @(posedge clk);
        for (int k = 0; k < LINE_WORDS; k++) begin
          #1;
          r_valid = 1;
          r_last  = (k == LINE_WORDS - 1);
          r_data  = memfn(la + 32'(4 * k));
          @(posedge clk);
        end
        #1;
        r_valid = 0;
        r_last  = 0;
        for (int k = 0; k < 50 && MemReq; k++) @(negedge clk);
        r_busy = 0;
      end
    end
  end

  // Monitor: refill address on every MemReq rise, MemReq drop after the last beat,
  // and the scoreboard pop when a pending fetch stops stalling.
  initial begin
    bit   prev_req, prev_last;
    int   stall_n;
    exp_t e;
    prev_req = 0; prev_last = 0; stall_n = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (MemReq && !prev_req) begin
          if (refill_q.size() == 0) chk("unexpected_memreq", {32'h0, MemAddr}, 64'h0);
          else chk("memaddr", {32'h0, MemAddr}, {32'h0, refill_q.pop_front()});
        end
        if (prev_last) chk("memreq_after_last", {63'h0, MemReq}, 64'h0);
      end
      prev_req  = MemReq;
      prev_last = MemReq && MemValid && MemLast && !reset;
      if (pending) begin
        if (Stall) begin
          if (stall_n == 0) begin
            chk("miss_instr", Instr, 64'h0);
            chk("miss_tlb", {63'h0, TLBExpection}, 64'h0);
          end
          stall_n++;
        end else begin
          e = exp_q.pop_front();
          chk("instr", Instr, e.instr);
          chk("tlb", {63'h0, TLBExpection}, {63'h0, e.tlb});
          chk("stall_cycles", 64'(stall_n), 64'(e.stall));
          stall_n = 0;
          pending = 0;
        end
      end
    end
  end

  initial begin
    logic [31:0] a;
    logic [23:0] tp;
    reset = 1; Addr = 0; s_valid = 0; s_last = 0; s_data = 0;
    for (int i = 0; i < LINES; i++) begin res_v[i] = 0; res_la[i] = 0; end
    repeat (3) @(posedge clk);
    #1;
    // Cold fetch of line 0, aborted by reset after two beats.
    refill_q.push_back(32'h0);
    reset = 0;
    @(negedge clk);
    chk("rst_stall", {63'h0, Stall}, 64'h1);
    chk("rst_memreq", {63'h0, MemReq}, 64'h0);
    chk("rst_memaddr", {32'h0, MemAddr}, 64'h0);
    chk("rst_instr", Instr, 64'h0);
    chk("rst_tlb", {63'h0, TLBExpection}, 64'h0);
    @(posedge clk);
    repeat (5) @(posedge clk);
    #1;
    reset = 1;
    @(posedge clk);
    @(negedge clk);
    chk("abort_memreq", {63'h0, MemReq}, 64'h0);
    chk("abort_stall", {63'h0, Stall}, 64'h1);
    for (int k = 0; k < 30; k++) begin
      if (!r_busy) break;
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    reset = 0;
    issue(32'h0000_0000);
    chk("cold_pair", Instr, 64'h0000_0022_0000_0011);
    issue(32'h0000_000C);
    chk("cross_pair", Instr, 64'h0000_0000_0000_0044);
    issue(32'h0000_0000);
    for (int k = 0; k < 4; k++) begin
      s_valid = 1;
      s_last  = 1'($urandom_range(0, 1));
      s_data  = $urandom;
      @(negedge clk);
      chk("stray_stall", {63'h0, Stall}, 64'h0);
      chk("stray_instr", Instr, {memfn(32'h4), memfn(32'h0)});
      chk("stray_memreq", {63'h0, MemReq}, 64'h0);
      @(posedge clk);
      #1;
    end
    s_valid = 0;
    s_last  = 0;
    issue(32'h0000_0100);
    issue(32'h0000_0000);
    issue(32'hFFFF_FFF0);
    issue(32'h0000_0100);
    issue(32'hFFFF_FFFC);
    issue(32'h0000_0000);
    issue(32'hFFFF_FFFC);
    chk("wrap_pair", Instr, {32'h0000_0011, memfn(32'hFFFF_FFFC)});
    for (int n = 0; n < 200; n++) begin
      case ($urandom_range(0, 2))
        0:       tp = 24'h0;
        1:       tp = 24'h1;
        default: tp = 24'hFF_FFFF;
      endcase
      a = {tp, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
      issue(a);
    end
    repeat (2) @(posedge clk);
    summary_and_finish();
  end

endmodule
